mux8_rr_sched: RTL and testbench
================================

// Module: mux8_rr_sched
// PURPOSE
//  Round-robin scheduler that shares the 8:1 bit-mux (mux8) between eight
//  serial requesters. Grants one requester for a burst of BURST_LEN beats,
//  drives the mux8 select, and streams the selected bit downstream over a
//  valid/ready handshake. Instantiates mux8 internally; sits between the
//  eight bit-serial sources and a single serial sink.
// PARAMETERS
//  BURST_LEN  8  beats per grant; legal range 1..256
//  CW         derived = max(1,$clog2(BURST_LEN)); beat counter width
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  req        in   8   req[i]=1: requester i has data; held for whole burst
//  data_in    in   8   data_in[i] = current serial bit of requester i
//  out_ready  in   1   sink accepts beat when out_valid & out_ready
//  out_valid  out  1   beat on out_data is valid
//  out_data   out  1   mux8 output = data_in[sel]
//  sel        out  3   registered mux8 select = index of granted requester
//  gnt        out  8   one-hot grant; all-zero when not in XFER
//  ack        out  8   one-hot pulse: beat of requester i accepted this cycle
//  busy       out  1   1 while in XFER
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, ptr=0, sel=0, gnt=0, cnt=0;
//   out_valid=0, ack=0, busy=0. Reset mid-burst discards the burst; no ack.
//  States: IDLE, XFER (1-bit state register).
//  IDLE: if req!=0, select first i with req[i]=1 searching ptr,ptr+1..7,0..
//   (mod 8); register sel<=i, gnt<=1<<i, cnt<=0, go XFER. req=0: stay IDLE.
//   Arbitration latency 1 cycle: req rise at edge N -> out_valid at edge N+1.
//  XFER: out_valid = req[sel] (combinational); out_data = data_in[sel]
//   through mux8 with s=sel (zero-latency combinational path).
//   Handshake hs = out_valid & out_ready; ack = hs ? gnt : 8'h00.
//   hs & cnt<BURST_LEN-1: cnt<=cnt+1, stay XFER.
//   hs & cnt==BURST_LEN-1: burst done; ptr<=sel+1 (7 wraps to 0), gnt<=0,
//    go IDLE.
//   out_ready=0: hold sel/cnt; out_data follows data_in[sel] (source must
//    hold its bit until ack).
//   req[sel]=0 (abort): out_valid=0 that cycle, no ack; ptr<=sel+1,
//    gnt<=0, go IDLE. Partial burst not resumed.
//  Fairness: granted requester gets lowest priority next arbitration;
//   one IDLE bubble between bursts (max throughput BURST_LEN/(BURST_LEN+1)).
//  req changes of non-granted requesters during XFER are ignored until IDLE.
//  BURST_LEN=1: every accepted beat ends the burst; cnt stays 0.
//  sel holds last granted index in IDLE (no glitching of mux8 select).
// TESTING
//  T1 reset: rst_n=0 asserted mid-XFER -> same cycle out_valid=0,gnt=0,
//   busy=0,ack=0; after release with req=0, stays IDLE.
//  T2 single: req=8'h04, out_ready=1, BURST_LEN=8 -> 1 cycle later sel=2,
//   gnt=8'h04; 8 consecutive ack=8'h04 with out_data=data_in[2]; then IDLE.
//  T3 round-robin: req=8'hFF held, out_ready=1 -> grants in order 0,1,..,7,0;
//   each burst 8 beats, one bubble cycle between bursts.
//  T4 wrap/priority: after grant to 7, req=8'h81 -> grant 0 next, then 7.
//  T5 backpressure: in XFER toggle out_ready 1,0,0,1 -> ack only on ready
//   cycles, cnt advances only then; burst still exactly BURST_LEN acks.
//  T6 abort: grant 3, drop req[3] after 3 acks -> out_valid=0 next cycle,
//   IDLE, next grant searches from 4 (req=8'h09 -> grants 0).

Source files
------------

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler sharing one 8:1 bit-mux between eight serial requesters.
// Grants one requester per burst of BURST_LEN beats, streamed over valid/ready.

module mux8 (
  input  logic [7:0] d,
  input  logic [2:0] s,
  output logic       y
);
  assign y = d[s];
endmodule

module mux8_rr_sched #(
  parameter int BURST_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] data_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       out_data,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic [7:0] ack,
  output logic       busy
);
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [2:0]    ptr_reg, ptr_next;
  logic [2:0]    sel_reg, sel_next;
  logic [7:0]    gnt_reg, gnt_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic [2:0] rot_idx [8];
  logic [7:0] req_rot;
  logic [2:0] pick_off;
  logic [2:0] pick_idx;
  logic       granted_req;
  logic       hs;
  logic       last_beat;

  // Rotate requests so that bit 0 is the requester at ptr; lowest set bit wins.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      assign rot_idx[gi] = ptr_reg + 3'(gi);
      assign req_rot[gi] = req[rot_idx[gi]];
    end
  endgenerate

  always_comb begin
    pick_off = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (req_rot[k]) pick_off = 3'(k);
    end
  end

  assign pick_idx    = ptr_reg + pick_off;
  assign granted_req = req[sel_reg];
  assign hs          = out_valid & out_ready;
  assign last_beat   = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= 3'd0;
      sel_reg   <= 3'd0;
      gnt_reg   <= 8'h00;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
      gnt_reg   <= gnt_next;
      cnt_reg   <= cnt_next;
    end
  end

  // A dropped request ends the burst exactly like a completed one.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    gnt_next   = gnt_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next = XFER;
          sel_next   = pick_idx;
          gnt_next   = 8'h01 << pick_idx;
          cnt_next   = '0;
        end
      end
      XFER: begin
        if (!granted_req || (hs && last_beat)) begin
          state_next = IDLE;
          ptr_next   = sel_reg + 3'd1;
          gnt_next   = 8'h00;
        end else if (hs) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_reg == XFER);
    out_valid = busy & granted_req;
    ack       = (out_valid & out_ready) ? gnt_reg : 8'h00;
  end

  assign sel = sel_reg;
  assign gnt = gnt_reg;

  mux8 u_mux8 (
    .d (data_in),
    .s (sel_reg),
    .y (out_data)
  );

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Self-checking bench for mux8_rr_sched: directed scenarios plus random traffic,
// compared every cycle against a burst-level reference model.

module tb_mux8_rr_sched;
  localparam int BURST_LEN = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] data_in;
  logic       out_ready;
  logic       out_valid;
  logic       out_data;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic [7:0] ack;
  logic       busy;

  int tests = 0;
  int fails = 0;

  // Reference model: who owns the mux, beats delivered, where the next search starts.
  bit m_active;
  int m_owner;
  int m_sel;
  int m_beats;
  int m_next;

  bit prev_busy;
  int gq[$];
  int ack_cnt;

  mux8_rr_sched #(.BURST_LEN(BURST_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .gnt       (gnt),
    .ack       (ack),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_owner  = 0;
    m_sel    = 0;
    m_beats  = 0;
    m_next   = 0;
  endtask

  task automatic check_model();
    logic [7:0] e_gnt;
    logic       e_valid;
    e_gnt   = m_active ? (8'h01 << m_owner) : 8'h00;
    e_valid = m_active && req[m_owner];
    chk("busy",      8'(busy),      8'(m_active));
    chk("gnt",       gnt,           e_gnt);
    chk("sel",       8'(sel),       8'(m_sel));
    chk("out_valid", 8'(out_valid), 8'(e_valid));
    chk("out_data",  8'(out_data),  8'(data_in[m_sel]));
    chk("ack",       ack,           (e_valid && out_ready) ? e_gnt : 8'h00);
  endtask

  task automatic model_step();
    if (!m_active) begin
      for (int k = 0; k < 8; k++) begin
        int i;
        i = (m_next + k) % 8;
        if (req[i]) begin
          m_owner  = i;
          m_sel    = i;
          m_beats  = 0;
          m_active = 1'b1;
          break;
        end
      end
    end else if (!req[m_owner]) begin
      m_next   = (m_owner + 1) % 8;
      m_active = 1'b0;
    end else if (out_ready) begin
      m_beats++;
      if (m_beats == BURST_LEN) begin
        m_next   = (m_owner + 1) % 8;
        m_active = 1'b0;
      end
    end
  endtask

  task automatic cycle(input logic [7:0] r, input logic rdy);
    @(negedge clk);
    req       = r;
    out_ready = rdy;
    data_in   = 8'($urandom);
    #1;
    check_model();
    if (busy && !prev_busy) gq.push_back(int'(sel));
    prev_busy = busy;
    if (ack != 8'h00) begin
      ack_cnt++;
      $display("[TB] t=%0t beat from requester %0d data=%0b", $time, sel, out_data);
    end
    model_step();
  endtask

  initial begin
    logic [7:0] r;
    logic [3:0] pat;
    rst_n     = 1'b0;
    req       = 8'h00;
    data_in   = 8'h00;
    out_ready = 1'b0;
    prev_busy = 1'b0;
    ack_cnt   = 0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  8'(busy),      8'h00);
    chk("rst_gnt",   gnt,           8'h00);
    chk("rst_valid", 8'(out_valid), 8'h00);
    chk("rst_ack",   ack,           8'h00);
    chk("rst_sel",   8'(sel),       8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // T2: single requester, full burst
    ack_cnt = 0;
    cycle(8'h04, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      cycle(8'h04, 1'b1);
      if (k == 1) begin
        chk("t2_sel", 8'(sel), 8'd2);
        chk("t2_gnt", gnt, 8'h04);
      end
    end
    chk("t2_acks", 8'(ack_cnt), 8'd8);
    cycle(8'h04, 1'b1);

    // T1: asynchronous reset in the middle of a burst
    @(negedge clk);
    #2;
    chk("t1_pre_busy", 8'(busy), 8'h01);
    rst_n = 1'b0;
    #1;
    chk("t1_valid", 8'(out_valid), 8'h00);
    chk("t1_gnt",   gnt,           8'h00);
    chk("t1_busy",  8'(busy),      8'h00);
    chk("t1_ack",   ack,           8'h00);
    model_reset();
    prev_busy = 1'b0;
    @(negedge clk);
    req   = 8'h00;
    rst_n = 1'b1;
    repeat (3) cycle(8'h00, 1'b1);

    // T3: all requesting, grants rotate 0..7,0
    gq.delete();
    repeat (76) cycle(8'hFF, 1'b1);
    chk("t3_count", 8'(gq.size()), 8'd9);
    for (int k = 0; k < 9; k++)
      chk($sformatf("t3_grant%0d", k), (k < gq.size()) ? 8'(gq[k]) : 8'hEE, 8'(k % 8));

    // T4: wrap from 7 back to 0, then 7 again
    cycle(8'h80, 1'b1);
    cycle(8'h80, 1'b1);
    gq.delete();
    repeat (20) cycle(8'h81, 1'b1);
    chk("t4_count", 8'(gq.size()), 8'd3);
    chk("t4_g0", (gq.size() > 0) ? 8'(gq[0]) : 8'hEE, 8'd7);
    chk("t4_g1", (gq.size() > 1) ? 8'(gq[1]) : 8'hEE, 8'd0);
    chk("t4_g2", (gq.size() > 2) ? 8'(gq[2]) : 8'hEE, 8'd7);

    // T5: backpressure with ready pattern 1,0,0,1
    cycle(8'h00, 1'b1);
    cycle(8'h00, 1'b1);
    ack_cnt = 0;
    pat     = 4'b1001;
    cycle(8'h20, 1'b1);
    for (int k = 1; k <= 16; k++) cycle(8'h20, pat[(k - 1) % 4]);
    cycle(8'h00, 1'b1);
    chk("t5_acks", 8'(ack_cnt), 8'd8);
    chk("t5_idle", 8'(busy), 8'h00);

    // T6: abort after three beats, next search starts past the aborted index
    cycle(8'h08, 1'b1);
    repeat (3) cycle(8'h08, 1'b1);
    cycle(8'h00, 1'b1);
    chk("t6_valid", 8'(out_valid), 8'h00);
    chk("t6_ack",   ack,           8'h00);
    cycle(8'h09, 1'b1);
    cycle(8'h09, 1'b1);
    chk("t6_sel", 8'(sel), 8'd0);
    chk("t6_gnt", gnt,     8'h01);

    // Random traffic with occasional request changes and random backpressure
    r = 8'h00;
    repeat (400) begin
      if ($urandom_range(0, 7) == 0)
        r = ($urandom_range(0, 1) == 0) ? 8'($urandom) : (8'($urandom) & 8'($urandom));
      cycle(r, 1'($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
